// File: rtl/serial_xor_reducer.sv
// serial_xor_reducer: bit-serial XOR-reduce and popcount of a word, LSB first, with valid/ready handshakes
module mux2 (
  input  logic sel,
  input  logic a,
  input  logic b,
  output logic y
);
  // plain 2:1 select, b when sel is high
  always_comb y = sel ? b : a;
endmodule

module serial_xor_reducer #(
  parameter int WIDTH = 8,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic          in_inv,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_parity,
  output logic [CW-1:0] out_ones
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic acc_q, acc_d;
  logic [CW-1:0] ones_q, ones_d, cnt_q, cnt_d;
  logic bit_n, acc_x;
  mux2 u_inv (.sel(sh_q[0]), .a(1'b1), .b(1'b0), .y(bit_n));
  mux2 u_sel (.sel(acc_q), .a(sh_q[0]), .b(bit_n), .y(acc_x));
  assign in_ready   = state_q == IDLE;
  assign out_valid  = state_q == DONE;
  assign out_parity = acc_q;
  assign out_ones   = ones_q;
  // next state: load on accept, fold one bit per SHIFT edge, release on output handshake
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    acc_d   = acc_q;
    ones_d  = ones_q;
    cnt_d   = cnt_q;
    if (state_q == IDLE && in_valid) begin
      state_d = SHIFT;
      sh_d    = in_data;
      acc_d   = in_inv;
      ones_d  = '0;
      cnt_d   = '0;
    end else if (state_q == SHIFT) begin
      acc_d   = acc_x;
      ones_d  = ones_q + CW'(sh_q[0]);
      sh_d    = sh_q >> 1;
      cnt_d   = cnt_q + 1'b1;
      state_d = cnt_q == CW'(WIDTH - 1) ? DONE : SHIFT;
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  // state registers; reset wins over any handshake on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      acc_q   <= 1'b0;
      ones_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      acc_q   <= acc_d;
      ones_q  <= ones_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_serial_xor_reducer.sv
// tb_serial_xor_reducer: directed checks on an 8-bit instance plus random traffic on 1/8/64-bit instances
module tb_serial_xor_reducer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int checks = 0;
  int failures = 0;
  int rand_done = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  logic rst, iv, ir, inv, ov, ordy, op;
  logic [7:0] d;
  logic [3:0] oo;
  serial_xor_reducer #(.WIDTH(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir), .in_data(d), .in_inv(inv),
    .out_valid(ov), .out_ready(ordy), .out_parity(op), .out_ones(oo)
  );
  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_ready", ir, 1);
    chk("rst_valid", ov, 0);
    chk("rst_par", op, 0);
    chk("rst_ones", oo, 0);
  endtask
  task automatic accept(input logic [7:0] v, input logic i);
    iv = 1'b1;
    d = v;
    inv = i;
    tick();
    iv = 1'b0;
    chk("acc_ready_low", ir, 0);
  endtask
  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!ov && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, n, 8);
  endtask
  task automatic txn(input logic [7:0] v, input logic i, input logic ep, input logic [3:0] eo, input string tag);
    accept(v, i);
    wait_done(tag);
    chk({tag, "_par"}, op, ep);
    chk({tag, "_ones"}, oo, eo);
    ordy = 1'b1;
    tick();
    ordy = 1'b0;
    chk({tag, "_idle"}, ir, 1);
    chk({tag, "_valid_low"}, ov, 0);
  endtask
  task automatic quiet(input string tag);
    int hits;
    hits = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (ov) hits++;
    end
    chk(tag, hits, 0);
  endtask
  initial begin
    int guard;
    rst = 1'b0; iv = 1'b0; d = '0; inv = 1'b0; ordy = 1'b0;
    do_reset();
    txn(8'hA5, 1'b0, 1'b0, 4'd4, "basic");
    txn(8'hFF, 1'b1, 1'b1, 4'd8, "ff_inv");
    txn(8'h01, 1'b0, 1'b1, 4'd1, "one");
    txn(8'h00, 1'b1, 1'b1, 4'd0, "zero_inv");
    accept(8'h3C, 1'b0);
    wait_done("bp");
    for (int c = 0; c < 5; c++) begin
      chk("bp_valid", ov, 1);
      chk("bp_ready", ir, 0);
      chk("bp_par", op, 0);
      chk("bp_ones", oo, 4);
      tick();
    end
    ordy = 1'b1;
    tick();
    ordy = 1'b0;
    chk("bp_idle", ir, 1);
    accept(8'hA5, 1'b0);
    iv = 1'b1;
    d = 8'h0F;
    ordy = 1'b1;
    wait_done("ign");
    chk("ign_par", op, 0);
    chk("ign_ones", oo, 4);
    iv = 1'b0;
    tick();
    ordy = 1'b0;
    chk("ign_idle", ir, 1);
    quiet("ign_single");
    iv = 1'b1; d = 8'hFF; inv = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; iv = 1'b0;
    chk("rst_over_acc", ir, 1);
    tick();
    chk("rst_over_acc2", ir, 1);
    accept(8'hFF, 1'b1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_ready", ir, 1);
    chk("mid_valid", ov, 0);
    chk("mid_par", op, 0);
    chk("mid_ones", oo, 0);
    quiet("mid_no_pulse");
    txn(8'h03, 1'b0, 1'b0, 4'd2, "after_rst");
    guard = 0;
    while (rand_done < 3 && guard < 95000) begin
      tick();
      guard++;
    end
    chk("rand_done", rand_done, 3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  for (genvar g = 0; g < 3; g++) begin : g_rand
    localparam int W = g == 0 ? 1 : g == 1 ? 8 : 64;
    localparam int CW = $clog2(W + 1);
    logic r_rst, r_iv, r_ir, r_inv, r_ov, r_or, r_op;
    logic [W-1:0] r_d;
    logic [CW-1:0] r_oo;
    serial_xor_reducer #(.WIDTH(W)) u_dut (
      .clk(clk), .rst(r_rst), .in_valid(r_iv), .in_ready(r_ir), .in_data(r_d), .in_inv(r_inv),
      .out_valid(r_ov), .out_ready(r_or), .out_parity(r_op), .out_ones(r_oo)
    );
    initial begin
      int n, cyc, acc_cyc, e;
      int q[$];
      logic s_ir, s_ov, s_op, ov_was;
      logic [CW-1:0] s_oo;
      logic [63:0] r;
      n = 0; cyc = 0; acc_cyc = 0; ov_was = 1'b0;
      r_rst = 1'b1; r_iv = 1'b0; r_d = '0; r_inv = 1'b0; r_or = 1'b0;
      tick();
      r_rst = 1'b0;
      while (n < 1000 && cyc < 90000) begin
        s_ir = r_ir; s_ov = r_ov; s_op = r_op; s_oo = r_oo;
        if (s_ov && !ov_was) chk($sformatf("w%0d_lat", W), cyc - acc_cyc, W);
        if (s_ir && s_ov) chk($sformatf("w%0d_excl", W), 1, 0);
        ov_was = s_ov;
        r = {$urandom, $urandom};
        r_d = r[W-1:0];
        r_inv = 1'($urandom_range(0, 1));
        r_iv = $urandom_range(0, 3) != 0;
        r_or = $urandom_range(0, 3) != 0;
        tick();
        cyc++;
        if (r_iv && s_ir) begin
          q.push_back(2 * $countones(r_d) + int'((^r_d) ^ r_inv));
          acc_cyc = cyc;
        end
        if (s_ov && r_or) begin
          chk($sformatf("w%0d_inflight", W), q.size(), 1);
          if (q.size() > 0) begin
            e = q.pop_front();
            chk($sformatf("w%0d_par", W), s_op, e & 1);
            chk($sformatf("w%0d_ones", W), s_oo, e >> 1);
          end
          n++;
        end
      end
      chk($sformatf("w%0d_count", W), n, 1000);
      rand_done++;
    end
  end
endmodule

// File: doc/serial_xor_reducer.md
SERIAL_XOR_REDUCER -- requirements
Module: serial_xor_reducer

Interface
REQ-001 Parameter: WIDTH, default 8, number of data bits reduced per transaction; legal range 1..64.
REQ-002 Localparam: CW = $clog2(WIDTH+1), width of the bit counter and the ones count.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  reset, synchronous and active-high.
REQ-005 Port: in_valid  input  1  upstream offers a word.
REQ-006 Port: in_ready  output  1  block accepts a word this cycle.
REQ-007 Port: in_data  input  WIDTH  word to reduce.
REQ-008 Port: in_inv  input  1  result inversion; 1 gives odd-parity fill, 0 gives plain XOR.
REQ-009 Port: out_valid  output  1  result held and offered downstream.
REQ-010 Port: out_ready  input  1  downstream accepts the result.
REQ-011 Port: out_parity  output  1  (^in_data) ^ in_inv of the accepted word.
REQ-012 Port: out_ones  output  CW  count of 1 bits in the accepted word.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-014 in_ready SHALL be 1 only in IDLE.
REQ-015 out_valid SHALL be 1 only in DONE.
REQ-016 Accept: when state is IDLE and in_valid=1 on an edge, the block SHALL:
  - load in_data into a shift register;
  - load in_inv into the parity accumulator;
  - clear the bit counter and the ones accumulator;
  - enter SHIFT.
REQ-017 In SHIFT, each edge SHALL process shift-register bit 0 (LSB first):
  - accumulator = accumulator XOR bit;
  - ones accumulator += bit;
  - shift register shifts right by one;
  - counter increments.
REQ-018 The per-bit XOR in REQ-017 SHALL be built only from instances of the existing 2:1 mux module (inverted-operand mux feeding a select-by-accumulator mux). No XOR operator is used for this datapath.
REQ-019 The edge that processes the WIDTH-th bit SHALL move the FSM to DONE. A word accepted on edge k therefore raises out_valid in the cycle after edge k+WIDTH.
REQ-020 In DONE, out_parity and out_ones SHALL stay stable until the handshake edge.
REQ-021 In DONE, an edge with out_ready=1 SHALL return the FSM to IDLE. A new word can be accepted no earlier than the following edge (throughput: one word per WIDTH+2 cycles).
REQ-022 in_valid and in_data SHALL be ignored outside IDLE. Changes to them during SHIFT or DONE SHALL NOT affect the result.
REQ-023 out_ready SHALL be ignored outside DONE.
REQ-024 WIDTH=1 SHALL give exactly one SHIFT cycle.
REQ-025 The all-ones word with WIDTH=64 SHALL give out_ones=64 without overflow, because CW=7.
REQ-026 out_parity and out_ones SHALL be registered outputs with no combinational path from in_data.

Reset
REQ-027 rst=1 on an edge SHALL put the FSM in IDLE and clear the shift register, accumulators and counter. It SHALL override any simultaneous accept or output handshake.
REQ-028 After reset the outputs SHALL be in_ready=1, out_valid=0, out_parity=0, out_ones=0.
REQ-029 A reset during SHIFT or DONE SHALL abandon the word in flight, and no out_valid pulse SHALL follow for it.

Verification
REQ-030 Basic reduction, WIDTH=8: in_data=8'hA5, in_inv=0, out_ready=1. Required: out_valid rises in the cycle after the 8th edge following accept, with out_parity=0 and out_ones=4.
REQ-031 Inversion, WIDTH=8: in_data=8'hFF, in_inv=1 gives out_parity=1, out_ones=8. in_data=8'h01, in_inv=0 gives out_parity=1, out_ones=1. in_data=8'h00, in_inv=1 gives out_parity=1, out_ones=0.
REQ-032 Backpressure: hold out_ready=0 for 5 cycles in DONE. Required: out_valid=1 and the outputs stay stable for all 5 cycles, in_ready=0 throughout, and IDLE is entered one edge after out_ready rises.
REQ-033 Ignored input: change in_data to 8'h0F and hold in_valid=1 during SHIFT of 8'hA5. Required: the result is still parity 0, ones 4, and exactly one transaction is produced.
REQ-034 Mid-operation reset: assert rst on the 3rd SHIFT edge. Required: next cycle in_ready=1, out_valid=0, outputs 0, and a following word 8'h03 gives parity 0, ones 2.
REQ-035 Random: WIDTH=1, 8 and 64, with 1000 random words each and random out_ready. Outputs SHALL match a reference model of popcount and XOR-reduce, with no lost or duplicated transactions.
